// File: rtl/alu_exec_seq.sv
// alu_exec_seq
// Sequencer that accepts one ALU request at a time, presents its operands to
// an external multi-cycle execution datapath for an opcode-dependent number
// of cycles, captures the datapath result, and holds it until the consumer
// takes it.
//
// Ports
//   clk, rst_n                 : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready        : request handshake (accepted when both high)
//   opcode, op_a, op_b         : request opcode (000 illegal) and 12-bit operands
//   exu_op, exu_a, exu_b       : operands presented to the datapath during EXEC
//   exu_res, exu_flag          : datapath result and overflow flag
//   res_valid / res_ready      : result handshake
//   result, ovf, err           : captured result, overflow, illegal-opcode error
//   ops_done                   : count of completed result handshakes (wraps)

module alu_exec_seq #(
  parameter int LAT_INT = 1,
  parameter int LAT_MUL = 3,
  parameter int LAT_FP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  opcode,
  input  logic [11:0] op_a,
  input  logic [11:0] op_b,
  output logic [2:0]  exu_op,
  output logic [11:0] exu_a,
  output logic [11:0] exu_b,
  input  logic [15:0] exu_res,
  input  logic        exu_flag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] result,
  output logic        ovf,
  output logic        err,
  output logic [7:0]  ops_done
);

  localparam logic [2:0] OP_ILLEGAL = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_SUB     = 3'b010;
  localparam logic [2:0] OP_UMUL    = 3'b011;
  localparam logic [2:0] OP_SMUL    = 3'b100;
  localparam logic [2:0] OP_FADD    = 3'b101;
  localparam logic [2:0] OP_FMUL    = 3'b110;
  localparam logic [2:0] OP_CMP     = 3'b111;

  // The counter is loaded with LAT-1 so that the capture edge lands exactly
  // LAT edges after the accepting edge.
  localparam logic [2:0] CNT_INT = 3'(LAT_INT - 1);
  localparam logic [2:0] CNT_MUL = 3'(LAT_MUL - 1);
  localparam logic [2:0] CNT_FP  = 3'(LAT_FP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic [2:0]  exu_op_nxt;
  logic [11:0] exu_a_nxt;
  logic [11:0] exu_b_nxt;
  logic [15:0] result_nxt;
  logic        ovf_nxt;
  logic        err_nxt;
  logic [7:0]  ops_done_nxt;
  logic        in_ready_nxt;
  logic        res_valid_nxt;

  function automatic logic [2:0] cnt_load(input logic [2:0] op);
    case (op)
      OP_UMUL, OP_SMUL: cnt_load = CNT_MUL;
      OP_FADD, OP_FMUL: cnt_load = CNT_FP;
      default:          cnt_load = CNT_INT;
    endcase
  endfunction

  // Integer-class results are 8 bits wide, float-class 12, multiplies 16.
  function automatic logic [15:0] mask_result(input logic [2:0]  op,
                                              input logic [15:0] res);
    case (op)
      OP_ADD, OP_SUB, OP_CMP: mask_result = {8'h00, res[7:0]};
      OP_FADD, OP_FMUL:       mask_result = {4'h0, res[11:0]};
      default:                mask_result = res;
    endcase
  endfunction

  // Only the multiplies and fmul can overflow; the flag is ignored otherwise.
  function automatic logic ovf_select(input logic [2:0] op,
                                      input logic       flag);
    case (op)
      OP_UMUL, OP_SMUL, OP_FMUL: ovf_select = flag;
      default:                   ovf_select = 1'b0;
    endcase
  endfunction

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      exu_op    <= OP_ILLEGAL;
      exu_a     <= 12'd0;
      exu_b     <= 12'd0;
      result    <= 16'd0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      ops_done  <= 8'd0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      exu_op    <= exu_op_nxt;
      exu_a     <= exu_a_nxt;
      exu_b     <= exu_b_nxt;
      result    <= result_nxt;
      ovf       <= ovf_nxt;
      err       <= err_nxt;
      ops_done  <= ops_done_nxt;
      in_ready  <= in_ready_nxt;
      res_valid <= res_valid_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    exu_op_nxt   = exu_op;
    exu_a_nxt    = exu_a;
    exu_b_nxt    = exu_b;
    result_nxt   = result;
    ovf_nxt      = ovf;
    err_nxt      = err;
    ops_done_nxt = ops_done;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (opcode == OP_ILLEGAL) begin
            // Illegal requests never touch the datapath.
            state_nxt  = HOLD;
            result_nxt = 16'd0;
            ovf_nxt    = 1'b0;
            err_nxt    = 1'b1;
          end else begin
            state_nxt  = EXEC;
            cnt_nxt    = cnt_load(opcode);
            exu_op_nxt = opcode;
            exu_a_nxt  = op_a;
            exu_b_nxt  = op_b;
          end
        end
      end

      EXEC: begin
        if (cnt == 3'd0) begin
          state_nxt  = HOLD;
          result_nxt = mask_result(exu_op, exu_res);
          ovf_nxt    = ovf_select(exu_op, exu_flag);
          err_nxt    = 1'b0;
          exu_op_nxt = OP_ILLEGAL;
          exu_a_nxt  = 12'd0;
          exu_b_nxt  = 12'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end

      HOLD: begin
        if (res_ready) begin
          state_nxt    = IDLE;
          ops_done_nxt = ops_done + 8'd1;
        end
      end

      default: begin
        state_nxt  = IDLE;
        cnt_nxt    = 3'd0;
        exu_op_nxt = OP_ILLEGAL;
        exu_a_nxt  = 12'd0;
        exu_b_nxt  = 12'd0;
      end
    endcase

    // Handshake flags are registered copies of the next state so that
    // in_ready stays low during reset and rises on the first edge after it.
    in_ready_nxt  = (state_nxt == IDLE);
    res_valid_nxt = (state_nxt == HOLD);
  end

endmodule

// File: doc/alu_exec_seq.md
ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
REQ-001 SHALL have parameter LAT_INT, default 1: cycles from issue to capture for opcodes 001, 010, 111 (legal range 1..8).
REQ-002 SHALL have parameter LAT_MUL, default 3: capture latency for opcodes 011, 100 (legal range 1..8).
REQ-003 SHALL have parameter LAT_FP, default 4: capture latency for opcodes 101, 110 (legal range 1..8).
REQ-004 SHALL have ports clk in 1 (sole clock, rising edge) and rst_n in 1 (asynchronous, active-low reset).
REQ-005 SHALL have ports in_valid in 1 (request present); in_ready out 1 (request accepted when both high).
REQ-006 SHALL have ports opcode in 3 (000 illegal, 001 add, 010 sub, 011 umul, 100 smul, 101 fadd, 110 fmul, 111 cmp); op_a in 12; op_b in 12.
REQ-007 SHALL have ports exu_op out 3, exu_a out 12, exu_b out 12 (drive to execution datapath); exu_res in 16, exu_flag in 1 (datapath result and overflow).
REQ-008 SHALL have ports res_valid out 1; res_ready in 1; result out 16; ovf out 1; err out 1; ops_done out 8 (completed-handshake count).

Function
REQ-009 SHALL implement states IDLE, EXEC, HOLD; in_ready=1 only in IDLE, res_valid=1 only in HOLD.
REQ-010 SHALL, in IDLE with in_valid=1 and legal opcode, latch opcode/op_a/op_b, load cnt=LAT-1 (per opcode class), go EXEC.
REQ-011 SHALL, in IDLE with in_valid=1 and opcode 000, go directly to HOLD with result=0, ovf=0, err=1, exu_op unchanged at 000.
REQ-012 SHALL drive exu_op/exu_a/exu_b from latched registers throughout EXEC, stable every cycle; exu_op=000 and exu_a=exu_b=0 in IDLE and HOLD.
REQ-013 SHALL, in EXEC with cnt=0, sample exu_res/exu_flag into result/ovf, set err=0, go HOLD; otherwise decrement cnt.
REQ-014 SHALL make res_valid rise exactly LAT cycles after the accepting edge (accept edge T0 -> res_valid high after edge T0+LAT).
REQ-015 SHALL mask result: opcodes 001/010/111 -> result[15:8]=0; 101/110 -> result[15:12]=0; 011/100 -> all 16 bits kept.
REQ-016 SHALL set ovf=exu_flag for 011, 100, 110 and ovf=0 for all other opcodes.
REQ-017 SHALL hold result/ovf/err/res_valid constant in HOLD until res_ready=1; on that edge go IDLE and drop res_valid.
REQ-018 SHALL keep result/ovf/err at last values in IDLE (res_valid=0 marks them stale).
REQ-019 SHALL increment ops_done by 1 on each res_valid&res_ready edge (illegal ops included), wrapping 255->0.
REQ-020 SHALL ignore in_valid/opcode/op_a/op_b changes outside IDLE; no request is queued.
REQ-021 SHALL allow res_ready high before HOLD without effect; handshake completes on first HOLD cycle if res_ready=1 (one-cycle HOLD).

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, cnt=0, in_ready=0, res_valid=0, result=0, ovf=0, err=0, ops_done=0, exu_op=000, exu_a=exu_b=0.
REQ-023 SHALL, on rst_n assertion mid-EXEC or mid-HOLD, discard the in-flight operation with no res_valid pulse and no ops_done increment.
REQ-024 SHALL assert in_ready on the first rising edge of clk after rst_n deasserts.

Verification
REQ-025 SHALL pass: opcode 001, a=0x012, b=0x034, datapath model returns 0xFF46 after 1 cycle -> res_valid after 1 cycle, result=0x0046, ovf=0, err=0, ops_done=1.
REQ-026 SHALL pass: opcode 011, a=0x0FF, b=0x0FF, exu_res=0xFE01, exu_flag=1 -> res_valid exactly 3 cycles after accept, result=0xFE01, ovf=1; exu_a/exu_b stable all 3 cycles.
REQ-027 SHALL pass: opcode 000 with in_valid=1 -> res_valid next cycle, result=0x0000, err=1, exu_op stays 000.
REQ-028 SHALL pass: opcode 110 completes, res_ready held 0 for 5 cycles while in_valid=1 with new opcode 001 -> result/ovf stable, in_ready=0, new request accepted only after handshake returns to IDLE.
REQ-029 SHALL pass: rst_n pulsed low during cycle 2 of a 101 operation -> no res_valid, all outputs at reset values, in_ready=1 one edge after release.
REQ-030 SHALL pass: 256 back-to-back 010 operations with res_ready tied 1 -> ops_done returns to 0x00 after the 256th handshake.
